// File: rtl/mips_cpu_pkg.sv
// Shared types and constants for the MIPS multicycle core PC sequencer.
//   pc_seq_state_t    : redirect-buffer state (idle / redirect pending)
//   MIPS_RESET_VECTOR : architectural boot address
//   PC_STEP           : byte distance between sequential instructions
package mips_cpu_pkg;

    typedef enum logic [0:0] {
        StIdle,
        StPending
    } pc_seq_state_t;

    localparam logic [31:0] MIPS_RESET_VECTOR = 32'hBFC00000;
    localparam int unsigned PC_STEP           = 4;

endpackage

// File: rtl/mips_cpu_pc_seq_if.sv
// Bus between the control FSM / branch logic (master) and the PC sequencer (slave).
//   master drives : waitrequest, advance, redirect_valid/target, flush/flush_target
//   slave drives  : pc, pc_plus4, in_delay_slot, redirect_ignored
//                   addr_err (only with MIPS_CPU_PC_ALIGN_CHECK_EN defined)
interface mips_cpu_pc_seq_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              waitrequest;
    logic              advance;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_target;
    logic              flush;
    logic [ADDR_W-1:0] flush_target;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_plus4;
    logic              in_delay_slot;
    logic              redirect_ignored;
`ifdef MIPS_CPU_PC_ALIGN_CHECK_EN
    logic              addr_err;
`endif

    modport master (
        output waitrequest, advance, redirect_valid, redirect_target, flush, flush_target,
        input  pc, pc_plus4, in_delay_slot, redirect_ignored
`ifdef MIPS_CPU_PC_ALIGN_CHECK_EN
        , input addr_err
`endif
    );

    modport slave (
        input  waitrequest, advance, redirect_valid, redirect_target, flush, flush_target,
        output pc, pc_plus4, in_delay_slot, redirect_ignored
`ifdef MIPS_CPU_PC_ALIGN_CHECK_EN
        , output addr_err
`endif
    );

endinterface

// File: rtl/mips_cpu_pc_redirect_buf.sv
// Deferred-redirect buffer: holds a branch/jump target until its delay slots retire.
//   clk, reset   : clock, synchronous active-high reset
//   load_i       : capture load_tgt_i and arm DELAY_SLOTS countdown
//   step_i       : one delay-slot instruction retired
//   clear_i      : discard any pending redirect (flush)
//   pending_o    : a redirect is pending (current pc is a delay slot)
//   expire_o     : last delay slot is retiring; next pc is tgt_o
//   tgt_o        : captured target
module mips_cpu_pc_redirect_buf
    import mips_cpu_pkg::*;
#(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DELAY_SLOTS = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_i,
    input  logic [ADDR_W-1:0] load_tgt_i,
    input  logic              step_i,
    input  logic              clear_i,
    output logic              pending_o,
    output logic              expire_o,
    output logic [ADDR_W-1:0] tgt_o
);
    localparam logic [1:0] LoadCnt = 2'(DELAY_SLOTS);

    pc_seq_state_t     state_q, state_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] tgt_q, tgt_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            tgt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tgt_q   <= tgt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tgt_d   = tgt_q;
        if (clear_i) begin
            state_d = StIdle;
            cnt_d   = '0;
        end else if (load_i) begin
            state_d = StPending;
            cnt_d   = LoadCnt;
            tgt_d   = load_tgt_i;
        end else if (step_i && state_q == StPending) begin
            if (cnt_q == 2'd1) begin
                state_d = StIdle;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q - 2'd1;
            end
        end
    end

    assign pending_o = (state_q == StPending);
    assign expire_o  = (state_q == StPending) && (cnt_q == 2'd1);
    assign tgt_o     = tgt_q;

endmodule

// File: rtl/mips_cpu_pc_seq.sv
// Program-counter sequencer with branch delay slots, memory stall and flush redirect.
//   clk, reset : clock, synchronous active-high reset (pc forced to RESET_VECTOR while high)
//   bus        : mips_cpu_pc_seq_if.slave (advance/waitrequest, redirect, flush in;
//                pc, pc_plus4, in_delay_slot, redirect_ignored out)
// Optional feature macro MIPS_CPU_PC_ALIGN_CHECK_EN: loaded targets get bits [1:0]
// cleared and bus.addr_err pulses the cycle after a misaligned load.
// Priority per edge: reset > flush > accepted advance > hold.
module mips_cpu_pc_seq
    import mips_cpu_pkg::*;
#(
    parameter int unsigned ADDR_W       = 32,
    parameter logic [31:0] RESET_VECTOR = MIPS_RESET_VECTOR,
    parameter int unsigned DELAY_SLOTS  = 1
) (
    input  logic           clk,
    input  logic           reset,
    mips_cpu_pc_seq_if.slave bus
);
    localparam logic [ADDR_W-1:0] RstPc = ADDR_W'(RESET_VECTOR);

    function automatic logic [ADDR_W-1:0] fix_align(input logic [ADDR_W-1:0] a);
`ifdef MIPS_CPU_PC_ALIGN_CHECK_EN
        return {a[ADDR_W-1:2], 2'b00};
`else
        return a;
`endif
    endfunction

    logic [ADDR_W-1:0] pc_q, pc_d, pc_cur, pc_inc;
    logic              ign_q, ign_d;
    logic              adv;
    logic              buf_load, buf_step, pending, expire;
    logic [ADDR_W-1:0] tgt;
`ifdef MIPS_CPU_PC_ALIGN_CHECK_EN
    logic              err_q, err_d;
`endif

    assign adv    = bus.advance & ~bus.waitrequest;
    assign pc_cur = reset ? RstPc : pc_q;
    assign pc_inc = pc_cur + ADDR_W'(PC_STEP);

    mips_cpu_pc_redirect_buf #(
        .ADDR_W      (ADDR_W),
        .DELAY_SLOTS (DELAY_SLOTS)
    ) u_redirect_buf (
        .clk        (clk),
        .reset      (reset),
        .load_i     (buf_load),
        .load_tgt_i (fix_align(bus.redirect_target)),
        .step_i     (buf_step),
        .clear_i    (bus.flush),
        .pending_o  (pending),
        .expire_o   (expire),
        .tgt_o      (tgt)
    );

    always_comb begin
        pc_d     = pc_q;
        ign_d    = 1'b0;
        buf_load = 1'b0;
        buf_step = 1'b0;
`ifdef MIPS_CPU_PC_ALIGN_CHECK_EN
        err_d    = 1'b0;
`endif
        if (bus.flush) begin
            pc_d = fix_align(bus.flush_target);
`ifdef MIPS_CPU_PC_ALIGN_CHECK_EN
            err_d = (bus.flush_target[1:0] != 2'b00);
`endif
        end else if (adv) begin
            if (pending) begin
                buf_step = 1'b1;
                pc_d     = expire ? tgt : pc_inc;
                // A second redirect inside the delay window is dropped.
                ign_d    = bus.redirect_valid;
            end else if (bus.redirect_valid) begin
                if (DELAY_SLOTS == 0) begin
                    pc_d = fix_align(bus.redirect_target);
                end else begin
                    pc_d     = pc_inc;
                    buf_load = 1'b1;
                end
`ifdef MIPS_CPU_PC_ALIGN_CHECK_EN
                err_d = (bus.redirect_target[1:0] != 2'b00);
`endif
            end else begin
                pc_d = pc_inc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q  <= RstPc;
            ign_q <= 1'b0;
`ifdef MIPS_CPU_PC_ALIGN_CHECK_EN
            err_q <= 1'b0;
`endif
        end else begin
            pc_q  <= pc_d;
            ign_q <= ign_d;
`ifdef MIPS_CPU_PC_ALIGN_CHECK_EN
            err_q <= err_d;
`endif
        end
    end

    assign bus.pc               = pc_cur;
    assign bus.pc_plus4         = pc_inc;
    assign bus.in_delay_slot    = pending;
    assign bus.redirect_ignored = ign_q;
`ifdef MIPS_CPU_PC_ALIGN_CHECK_EN
    assign bus.addr_err         = err_q;
`endif

endmodule

// File: tb/tb_mips_cpu_pc_seq.sv
// Three sequencers (DELAY_SLOTS = 0, 1, 2) driven by one stimulus stream and checked
// against an abstract "scheduled redirect" model after every clock edge.
module tb_mips_cpu_pc_seq;
    localparam logic [31:0] RV = 32'hBFC00000;

    logic        clk = 1'b0;
    logic        reset, wr, adv, rv, fl;
    logic [31:0] rt, ft;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mips_cpu_pc_seq_if #(.ADDR_W(32)) bus0 ();
    mips_cpu_pc_seq_if #(.ADDR_W(32)) bus1 ();
    mips_cpu_pc_seq_if #(.ADDR_W(32)) bus2 ();

    assign bus0.waitrequest = wr;  assign bus1.waitrequest = wr;  assign bus2.waitrequest = wr;
    assign bus0.advance = adv;     assign bus1.advance = adv;     assign bus2.advance = adv;
    assign bus0.redirect_valid = rv;
    assign bus1.redirect_valid = rv;
    assign bus2.redirect_valid = rv;
    assign bus0.redirect_target = rt;
    assign bus1.redirect_target = rt;
    assign bus2.redirect_target = rt;
    assign bus0.flush = fl;        assign bus1.flush = fl;        assign bus2.flush = fl;
    assign bus0.flush_target = ft; assign bus1.flush_target = ft; assign bus2.flush_target = ft;

    mips_cpu_pc_seq #(.ADDR_W(32), .RESET_VECTOR(RV), .DELAY_SLOTS(0)) dut0 (
        .clk(clk), .reset(reset), .bus(bus0));
    mips_cpu_pc_seq #(.ADDR_W(32), .RESET_VECTOR(RV), .DELAY_SLOTS(1)) dut1 (
        .clk(clk), .reset(reset), .bus(bus1));
    mips_cpu_pc_seq #(.ADDR_W(32), .RESET_VECTOR(RV), .DELAY_SLOTS(2)) dut2 (
        .clk(clk), .reset(reset), .bus(bus2));

    // Model: per DUT, the architectural pc plus a scheduled redirect "left" instructions away.
    logic [31:0] m_pc  [3];
    logic [31:0] m_tgt [3];
    int          m_left[3];
    logic        m_ign [3];
    logic        m_err [3];

    function automatic logic [31:0] al(input logic [31:0] a);
`ifdef MIPS_CPU_PC_ALIGN_CHECK_EN
        return a & ~32'd3;
`else
        return a;
`endif
    endfunction

    task automatic model_edge();
        for (int i = 0; i < 3; i++) begin
            if (reset) begin
                m_pc[i] = RV; m_left[i] = 0; m_ign[i] = 1'b0; m_err[i] = 1'b0;
            end else begin
                m_ign[i] = 1'b0;
                m_err[i] = 1'b0;
                if (fl) begin
                    m_pc[i]   = al(ft);
                    m_left[i] = 0;
                    m_err[i]  = (ft % 4) != 0;
                end else if (adv && !wr) begin
                    if (m_left[i] > 0) begin
                        m_ign[i]  = rv;
                        m_left[i] = m_left[i] - 1;
                        m_pc[i]   = (m_left[i] == 0) ? m_tgt[i] : m_pc[i] + 32'd4;
                    end else if (rv) begin
                        m_err[i] = (rt % 4) != 0;
                        if (i == 0) begin
                            m_pc[i] = al(rt);
                        end else begin
                            m_pc[i]   = m_pc[i] + 32'd4;
                            m_tgt[i]  = al(rt);
                            m_left[i] = i;
                        end
                    end else begin
                        m_pc[i] = m_pc[i] + 32'd4;
                    end
                end
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_one(input int i, input logic [31:0] pc, input logic [31:0] pp4,
                             input logic ids, input logic ign, input logic err);
        logic [31:0] epc;
        epc = reset ? RV : m_pc[i];
        chk($sformatf("pc[%0d]", i), pc, epc);
        chk($sformatf("pc_plus4[%0d]", i), pp4, epc + 32'd4);
        chk($sformatf("in_delay_slot[%0d]", i), {31'd0, ids}, {31'd0, m_left[i] > 0});
        chk($sformatf("redirect_ignored[%0d]", i), {31'd0, ign}, {31'd0, m_ign[i]});
`ifdef MIPS_CPU_PC_ALIGN_CHECK_EN
        chk($sformatf("addr_err[%0d]", i), {31'd0, err}, {31'd0, m_err[i]});
`else
        if (err !== 1'b0) chk($sformatf("addr_err_tie[%0d]", i), {31'd0, err}, 32'd0);
`endif
    endtask

    task automatic check_all();
        logic e0, e1, e2;
`ifdef MIPS_CPU_PC_ALIGN_CHECK_EN
        e0 = bus0.addr_err; e1 = bus1.addr_err; e2 = bus2.addr_err;
`else
        e0 = 1'b0; e1 = 1'b0; e2 = 1'b0;
`endif
        check_one(0, bus0.pc, bus0.pc_plus4, bus0.in_delay_slot, bus0.redirect_ignored, e0);
        check_one(1, bus1.pc, bus1.pc_plus4, bus1.in_delay_slot, bus1.redirect_ignored, e1);
        check_one(2, bus2.pc, bus2.pc_plus4, bus2.in_delay_slot, bus2.redirect_ignored, e2);
    endtask

    task automatic step(input logic rst_, input logic wr_, input logic adv_, input logic rv_,
                        input logic [31:0] rt_, input logic fl_, input logic [31:0] ft_);
        reset = rst_; wr = wr_; adv = adv_; rv = rv_; rt = rt_; fl = fl_; ft = ft_;
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    initial begin
        reset = 1'b1; wr = 1'b0; adv = 1'b1; rv = 1'b0; rt = '0; fl = 1'b0; ft = '0;
        for (int i = 0; i < 3; i++) begin
            m_pc[i] = '0; m_tgt[i] = '0; m_left[i] = 0; m_ign[i] = 1'b0; m_err[i] = 1'b0;
        end

        // Reset held 3 cycles with advance high, then sequential fetch.
        repeat (3) step(1, 0, 1, 0, 0, 0, 0);
        chk("rst_pc", bus1.pc, 32'hBFC00000);
        step(0, 0, 1, 0, 0, 0, 0);
        chk("seq_pc1", bus1.pc, 32'hBFC00004);
        step(0, 0, 1, 0, 0, 0, 0);
        chk("seq_pc2", bus1.pc, 32'hBFC00008);

        // One delay slot, branch to 0x1000.
        step(0, 0, 1, 1, 32'h1000, 0, 0);
        chk("ds1_slot_pc", bus1.pc, 32'hBFC0000C);
        chk("ds1_slot_flag", {31'd0, bus1.in_delay_slot}, 32'd1);
        chk("ds0_direct", bus0.pc, 32'h1000);
        step(0, 0, 1, 0, 0, 0, 0);
        chk("ds1_taken", bus1.pc, 32'h1000);

        // Same branch with a 3-cycle stall in the delay slot.
        step(0, 0, 0, 0, 0, 1, 32'hBFC00008);
        step(0, 0, 1, 1, 32'h1000, 0, 0);
        repeat (3) step(0, 1, 1, 0, 0, 0, 0);
        chk("stall_hold", bus1.pc, 32'hBFC0000C);
        step(0, 0, 1, 0, 0, 0, 0);
        chk("stall_taken", bus1.pc, 32'h1000);

        // Two delay slots with a second redirect inside the window.
        step(0, 0, 0, 0, 0, 1, 32'h100);
        step(0, 0, 1, 1, 32'h2000, 0, 0);
        chk("ds2_slot1", bus2.pc, 32'h104);
        step(0, 0, 1, 1, 32'h3000, 0, 0);
        chk("ds2_slot2", bus2.pc, 32'h108);
        chk("ds2_ignored", {31'd0, bus2.redirect_ignored}, 32'd1);
        step(0, 0, 1, 0, 0, 0, 0);
        chk("ds2_taken", bus2.pc, 32'h2000);
        chk("ds2_ign_clr", {31'd0, bus2.redirect_ignored}, 32'd0);

        // Flush while pending and stalled.
        step(0, 0, 0, 0, 0, 1, 32'h100);
        step(0, 0, 1, 1, 32'h2000, 0, 0);
        step(0, 1, 1, 0, 0, 1, 32'h80000180);
        chk("flush_pc", bus1.pc, 32'h80000180);
        chk("flush_ids", {31'd0, bus1.in_delay_slot}, 32'd0);

        // Flush on the same edge as a target load.
        step(0, 0, 1, 1, 32'h4000, 1, 32'h500);
        step(0, 0, 1, 0, 0, 0, 0);

        // Wraparound.
        step(0, 0, 0, 0, 0, 1, 32'hFFFFFFFC);
        step(0, 0, 1, 0, 0, 0, 0);
        chk("wrap_pc", bus1.pc, 32'h0);

        // Reset while pending.
        step(0, 0, 0, 0, 0, 1, 32'h100);
        step(0, 0, 1, 1, 32'h2000, 0, 0);
        step(1, 0, 1, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0, 0);
        chk("rst_pend_pc", bus2.pc, 32'hBFC00004);

        // Misaligned target.
        step(0, 0, 0, 0, 0, 1, 32'h1000);
        step(0, 0, 1, 1, 32'h1002, 0, 0);
`ifdef MIPS_CPU_PC_ALIGN_CHECK_EN
        chk("align_pc", bus0.pc, 32'h1000);
        chk("align_err", {31'd0, bus0.addr_err}, 32'd1);
`endif
        step(0, 0, 1, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 1, 32'h2003);
        step(0, 0, 1, 0, 0, 0, 0);

        // Random traffic.
        for (int n = 0; n < 400; n++) begin
            logic [31:0] r_rt, r_ft;
            r_rt = $urandom;
            r_ft = $urandom;
            if ($urandom_range(0, 1) == 0) r_rt = r_rt & ~32'd3;
            if ($urandom_range(0, 1) == 0) r_ft = r_ft & ~32'd3;
            step(($urandom % 50) == 0, ($urandom % 4) == 0, ($urandom % 4) != 0,
                 ($urandom % 3) == 0, r_rt, ($urandom % 20) == 0, r_ft);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
